// File: rtl/dpll_pkg.sv
// Shared widths, direction encoding and control-word saturation for the bang-bang DPLL.
package dpll_pkg;

    localparam int CTRL_W_DEF = 20;
    localparam int ACC_W_DEF  = 24;
    localparam int SUM_W      = CTRL_W_DEF + 2;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Two guard bits let the loop sums go negative or above full scale without wrapping.
    function automatic logic [CTRL_W_DEF-1:0] sat_ctrl(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] max_v;
        max_v = $signed({2'b00, {CTRL_W_DEF{1'b1}}});
        if (v[SUM_W-1]) return '0;
        if (v > max_v) return '1;
        return v[CTRL_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/dpll_loop_filter.sv
// Proportional-integral loop filter: turns each phase-detector decision into a saturated control word.
module dpll_loop_filter
    import dpll_pkg::*;
#(
    parameter int KP        = 3000,
    parameter int KI        = 150,
    parameter int CTRL_INIT = 524288
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd,
    input  logic                  dir,
    output logic [CTRL_W_DEF-1:0] ctrl_word
);

    localparam logic signed [SUM_W-1:0] KP_S = SUM_W'(KP);
    localparam logic signed [SUM_W-1:0] KI_S = SUM_W'(KI);

    logic [CTRL_W_DEF-1:0]   integ;
    logic [CTRL_W_DEF-1:0]   integ_n;
    logic signed [SUM_W-1:0] integ_ext;
    logic signed [SUM_W-1:0] integ_sum;
    logic signed [SUM_W-1:0] integ_n_ext;
    logic signed [SUM_W-1:0] prop_sum;

    // The proportional kick rides on the already-updated integrator value.
    always_comb begin
        integ_ext   = $signed({2'b00, integ});
        integ_sum   = (dir == DIR_UP) ? integ_ext + KI_S : integ_ext - KI_S;
        integ_n     = sat_ctrl(integ_sum);
        integ_n_ext = $signed({2'b00, integ_n});
        prop_sum    = (dir == DIR_DN) ? integ_n_ext - KP_S : integ_n_ext + KP_S;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            integ     <= CTRL_W_DEF'(CTRL_INIT);
            ctrl_word <= CTRL_W_DEF'(CTRL_INIT);
        end else if (upd) begin
            integ     <= integ_n;
            ctrl_word <= sat_ctrl(prop_sum);
        end
    end

endmodule

// File: rtl/dpll_core.sv
// All-digital bang-bang PLL: reference synchronizer, phase detector, PI filter, phase-accumulator DCO, lock detect.
module dpll_core
    import dpll_pkg::*;
#(
    parameter int KP        = 3000,
    parameter int KI        = 150,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int CTRL_INIT = 524288,
    parameter int LOCK_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_in,
    output logic              dco_out,
    output logic              dir,
    output logic              pd_valid,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              lock
);

    localparam int               CNT_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic             s1, s2, s3;
    logic             ref_rise;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_n;
    logic             prev_dir;

    assign ref_rise = s2 & ~s3;
    assign dco_out  = acc[ACC_W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ref_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A low DCO at the reference edge means its rising edge is still to come: speed up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir      <= DIR_DN;
            pd_valid <= 1'b0;
        end else begin
            pd_valid <= ref_rise;
            if (ref_rise) dir <= ~dco_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc <= '0;
        else      acc <= acc + ACC_W'(ctrl_word);
    end

    always_comb begin
        lock_cnt_n = '0;
        if (dir != prev_dir) lock_cnt_n = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt <= '0;
            prev_dir <= DIR_DN;
            lock     <= 1'b0;
        end else if (pd_valid) begin
            lock_cnt <= lock_cnt_n;
            prev_dir <= dir;
            lock     <= (lock_cnt_n == CNT_MAX);
        end
    end

    dpll_loop_filter #(
        .KP        (KP),
        .KI        (KI),
        .CTRL_INIT (CTRL_INIT)
    ) u_lf (
        .clk       (clk),
        .rst       (rst),
        .upd       (pd_valid),
        .dir       (dir),
        .ctrl_word (ctrl_word)
    );

endmodule

// File: tb/tb_dpll_core.sv
// Scoreboard bench for dpll_core: nominal, near-full-scale and near-zero instances share one expectation queue.
module tb_dpll_core;

    typedef struct {
        int ch;
        int cyc;
        bit d;
        int ig;
        int cw;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m = 1'b0, rst_h = 1'b0, rst_l = 1'b0;
    logic ref_m = 1'b0, ref_h = 1'b0, ref_l = 1'b0;
    logic dco_m, dir_m, pv_m, lock_m;
    logic dco_h, dir_h, pv_h, lock_h;
    logic dco_l, dir_l, pv_l, lock_l;
    logic [19:0] cw_m, cw_h, cw_l;

    dpll_core #(.CTRL_INIT(524288)) dut (
        .clk(clk), .rst(rst_m), .ref_in(ref_m), .dco_out(dco_m), .dir(dir_m),
        .pd_valid(pv_m), .ctrl_word(cw_m), .lock(lock_m));

    dpll_core #(.CTRL_INIT(1048500)) dut_hi (
        .clk(clk), .rst(rst_h), .ref_in(ref_h), .dco_out(dco_h), .dir(dir_h),
        .pd_valid(pv_h), .ctrl_word(cw_h), .lock(lock_h));

    dpll_core #(.CTRL_INIT(100), .ACC_W(21)) dut_lo (
        .clk(clk), .rst(rst_l), .ref_in(ref_l), .dco_out(dco_l), .dir(dir_l),
        .pd_valid(pv_l), .ctrl_word(cw_l), .lock(lock_l));

    logic        pv [3];
    logic        dr [3];
    logic [19:0] cw [3];
    logic [19:0] ig [3];
    assign pv[0] = pv_m;  assign pv[1] = pv_h;  assign pv[2] = pv_l;
    assign dr[0] = dir_m; assign dr[1] = dir_h; assign dr[2] = dir_l;
    assign cw[0] = cw_m;  assign cw[1] = cw_h;  assign cw[2] = cw_l;
    assign ig[0] = dut.u_lf.integ;
    assign ig[1] = dut_hi.u_lf.integ;
    assign ig[2] = dut_lo.u_lf.integ;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t pe [3];
    bit   pend [3];
    bit   sb_en [3];
    bit   lk_en = 1'b0, lk_pend = 1'b0, lk_exp = 1'b0, mprev = 1'b0;
    int   mcnt = 0;
    int   lock_seen = 0;

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            if (lo == hi) $display("FAIL %s: got %0d, want %0d", nm, act, lo);
            else          $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_rng(nm, act, exp, exp);
    endtask

    task automatic set_ref(input int ch, input logic v);
        case (ch)
            0:       ref_m = v;
            1:       ref_h = v;
            default: ref_l = v;
        endcase
    endtask

    // Called on a falling edge; the PD decision lands on the third rising edge after it.
    task automatic pulse_one(input int ch, input bit d, input int igv, input int cwv);
        exp_t e;
        e.ch  = ch;
        e.cyc = cyc + 3;
        e.d   = d;
        e.ig  = igv;
        e.cw  = cwv;
        q.push_back(e);
        set_ref(ch, 1'b1);
        repeat (2) @(negedge clk);
        set_ref(ch, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((q.size() != 0 || pend[0] || pend[1] || pend[2]) && k < 40) begin
            @(posedge clk);
            k++;
        end
        chk(nm, q.size() + int'(pend[0]) + int'(pend[1]) + int'(pend[2]), 0);
    endtask

    // Monitor: PD pulses pop the queue; filter results and lock are checked one cycle later.
    initial begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            pend[i]  = 1'b0;
            sb_en[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 3; ch++) begin
                if (pend[ch]) begin
                    chk($sformatf("ch%0d_pd_width", ch), pv[ch], 0);
                    chk($sformatf("ch%0d_integ", ch), ig[ch], pe[ch].ig);
                    chk($sformatf("ch%0d_ctrl_word", ch), cw[ch], pe[ch].cw);
                    pend[ch] = 1'b0;
                end
                if (sb_en[ch] && pv[ch]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("ch%0d_unexpected_pd", ch), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("ch%0d_sb_chan", ch), ch, e.ch);
                        chk($sformatf("ch%0d_pd_cycle", ch), cyc, e.cyc);
                        chk($sformatf("ch%0d_dir", ch), dr[ch], e.d);
                        pe[ch]   = e;
                        pend[ch] = 1'b1;
                    end
                end
            end
            if (lk_pend) begin
                chk("cl_lock", lock_m, lk_exp);
                if (lock_m) lock_seen++;
                lk_pend = 1'b0;
            end
            if (lk_en && pv[0]) begin
                if (dr[0] != mprev) begin
                    if (mcnt < 16) mcnt++;
                end else begin
                    mcnt = 0;
                end
                mprev   = dr[0];
                lk_exp  = (mcnt == 16);
                lk_pend = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        int len;
        logic lvl;

        repeat (5) begin
            @(negedge clk);
            ref_m = 1'($urandom_range(0, 1));
            ref_h = 1'($urandom_range(0, 1));
            ref_l = 1'($urandom_range(0, 1));
        end
        chk("rst_ctrl_word", cw_m, 524288);
        chk("rst_integ", ig[0], 524288);
        chk("rst_dco_out", dco_m, 0);
        chk("rst_dir", dir_m, 0);
        chk("rst_pd_valid", pv_m, 0);
        chk("rst_lock", lock_m, 0);

        // Free run at mid-scale: 32-cycle period starting low
        @(negedge clk);
        ref_m = 1'b0; ref_h = 1'b0; ref_l = 1'b0;
        rst_m = 1'b1;
        k = cyc;
        while (!dco_m && cyc - k < 40) @(negedge clk);
        chk("fr_first_high_edges", cyc - k, 16);
        for (int s = 0; s < 3; s++) begin
            lvl = dco_m;
            len = 0;
            while (dco_m == lvl && len < 40) begin
                @(negedge clk);
                len++;
            end
            chk(lvl ? "fr_high_len" : "fr_low_len", len, 16);
        end
        chk("fr_ctrl_word", cw_m, 524288);

        // Single up-update while the DCO is still low
        @(negedge clk); rst_m = 1'b0;
        @(negedge clk); rst_m = 1'b1;
        pulse_one(0, 1'b1, 524438, 527438);
        drain("up_drain");

        // Asynchronous reset mid-run, checked before any clock edge
        @(negedge clk);
        rst_m = 1'b0;
        #1;
        chk("arst_ctrl_word", cw_m, 524288);
        chk("arst_integ", ig[0], 524288);
        chk("arst_dco_out", dco_m, 0);
        chk("arst_dir", dir_m, 0);
        chk("arst_pd_valid", pv_m, 0);
        chk("arst_lock", lock_m, 0);

        // Single down-update while the DCO is high
        @(negedge clk);
        rst_m = 1'b1;
        k = 0;
        while (!dco_m && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("dn_dco_high", dco_m, 1);
        pulse_one(0, 1'b0, 524138, 521138);
        drain("dn_drain");

        // Upper clamp: two speed-up decisions from just below full scale
        @(negedge clk);
        rst_h = 1'b1;
        chk("hi_dco_low", dco_h, 0);
        pulse_one(1, 1'b1, 1048575, 1048575);
        pulse_one(1, 1'b1, 1048575, 1048575);
        drain("hi_drain");
        chk("hi_lock", lock_h, 0);

        fork
            begin : closed_loop
                int first, last, n, avg100;
                logic dp;
                first = -1; last = 0; n = 0; dp = 1'b0;
                @(negedge clk);
                rst_m    = 1'b0;
                sb_en[0] = 1'b0;
                mcnt     = 0;
                mprev    = 1'b0;
                lk_en    = 1'b1;
                @(negedge clk);
                rst_m = 1'b1;
                for (int i = 0; i < 80000; i++) begin
                    @(negedge clk);
                    if (i % 17 == 0) ref_m = ~ref_m;
                    if (i >= 60000) begin
                        if (dco_m && !dp) begin
                            if (first < 0) first = cyc;
                            last = cyc;
                            n++;
                        end
                        dp = dco_m;
                    end
                end
                lk_en  = 1'b0;
                avg100 = (n > 1) ? (last - first) * 100 / (n - 1) : -1;
                chk_rng("cl_avg_period_x100", avg100, 3300, 3500);
                chk_rng("cl_lock_seen", lock_seen, 1, 1000000);
            end
            begin : low_clamp
                int m;
                @(negedge clk);
                rst_l = 1'b1;
                m = 0;
                while (!dco_l && m < 12000) begin
                    @(negedge clk);
                    m++;
                end
                chk("lo_dco_high", dco_l, 1);
                pulse_one(2, 1'b0, 0, 0);
                pulse_one(2, 1'b0, 0, 0);
                drain("lo_drain");
                m = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (dco_l) m++;
                end
                chk("lo_dco_hold", m, 50);
                chk("lo_lock", lock_l, 0);
            end
        join

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
